// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// One transaction per grant; memory-side outputs are registered, read data returns RD_LAT+1 cycles after GNT.

module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] d_addr,
    output logic              d_wr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_rdata,

    output logic              busy
);

    localparam int CNT_W     = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             sel;
    logic             any_req;
    logic             win;
    logic             arb_en;
    logic [CNT_W-1:0] wait_cnt;

    // On a tie the port that was not granted last wins.
    always_comb begin
        any_req = r0_req | r1_req;
        win     = (r0_req && r1_req) ? ~last : r1_req;
        arb_en  = any_req && ((state == S_IDLE) || (state == S_RESP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (d_wr) begin
                    state_nxt = S_IDLE;
                end else if (RD_LAT == 1) begin
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = any_req ? S_ACCESS : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // The winner's request is latched straight into the memory-side registers,
    // so they present the access during the ACCESS cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            sel     <= 1'b0;
            d_addr  <= '0;
            d_wr    <= 1'b0;
            d_wdata <= '0;
            r0_gnt  <= 1'b0;
            r1_gnt  <= 1'b0;
        end else begin
            r0_gnt <= 1'b0;
            r1_gnt <= 1'b0;
            d_wr   <= 1'b0;
            if (arb_en) begin
                sel     <= win;
                last    <= win;
                d_addr  <= win ? r1_addr  : r0_addr;
                d_wr    <= win ? r1_wr    : r0_wr;
                d_wdata <= win ? r1_wdata : r0_wdata;
                r0_gnt  <= ~win;
                r1_gnt  <= win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_ACCESS) begin
            wait_cnt <= CNT_W'(WAIT_INIT);
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Read data is on d_rdata during RESP; it is captured for the port that issued the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            if (state == S_RESP) begin
                if (sel) begin
                    r1_rvalid <= 1'b1;
                    r1_rdata  <= d_rdata;
                end else begin
                    r0_rvalid <= 1'b1;
                    r0_rdata  <= d_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) driven by queued requesters
// and checked each cycle against a transaction-level reference model.

module tb_dmem_arbiter;

    localparam int NI = 2;

    typedef struct packed {
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
    } txn_t;

    logic        clk;
    logic        rst_n;

    logic        req0  [NI];
    logic        wr0   [NI];
    logic [7:0]  addr0 [NI];
    logic [15:0] wd0   [NI];
    logic        gnt0  [NI];
    logic        rv0   [NI];
    logic [15:0] rd0   [NI];
    logic        req1  [NI];
    logic        wr1   [NI];
    logic [7:0]  addr1 [NI];
    logic [15:0] wd1   [NI];
    logic        gnt1  [NI];
    logic        rv1   [NI];
    logic [15:0] rd1   [NI];
    logic [7:0]  daddr [NI];
    logic        dwr   [NI];
    logic [15:0] dwd   [NI];
    logic [15:0] drd   [NI];
    logic        busy  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] mem [256] = '{default: 16'h0};
        logic [7:0]  apipe [LAT];

        dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .r0_req(req0[g]), .r0_wr(wr0[g]), .r0_addr(addr0[g]), .r0_wdata(wd0[g]),
            .r0_gnt(gnt0[g]), .r0_rvalid(rv0[g]), .r0_rdata(rd0[g]),
            .r1_req(req1[g]), .r1_wr(wr1[g]), .r1_addr(addr1[g]), .r1_wdata(wd1[g]),
            .r1_gnt(gnt1[g]), .r1_rvalid(rv1[g]), .r1_rdata(rd1[g]),
            .d_addr(daddr[g]), .d_wr(dwr[g]), .d_wdata(dwd[g]), .d_rdata(drd[g]),
            .busy(busy[g])
        );

        // Memory: write on the edge ending the write cycle, read data valid LAT cycles after the address.
        always @(posedge clk) begin
            if (dwr[g]) mem[daddr[g]] <= dwd[g];
            apipe[0] <= daddr[g];
            for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
        end
        assign drd[g] = mem[apipe[LAT-1]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          gaps  = 0;
    txn_t        q [4][$];
    bit          active [4];
    bit          gprev  [4];
    bit          gnow   [4];

    // Reference model state: expected events per cycle kept in small rings.
    int          free_at [NI];
    bit          last_m  [NI];
    bit          eg    [NI][2][16];
    bit          erv   [NI][2][16];
    logic [15:0] erd   [NI][2][16];
    bit          edwr  [NI][16];
    bit          ebusy [NI][16];
    logic [7:0]  eaddr [NI][16];
    logic [15:0] ewd   [NI][16];
    logic [15:0] hold  [NI][2];
    logic [15:0] mmem  [NI][256];
    int          dut_rv [NI];
    int          mdl_rv [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            for (int s = 0; s < 16; s++) begin
                for (int p = 0; p < 2; p++) begin
                    if (erv[i][p][s]) mdl_rv[i]--;
                    erv[i][p][s] = 0;
                    eg[i][p][s]  = 0;
                end
                edwr[i][s]  = 0;
                ebusy[i][s] = 0;
            end
            free_at[i] = 0;
            last_m[i]  = 1;
            hold[i][0] = '0;
            hold[i][1] = '0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            int   i;
            int   p;
            txn_t t;
            i = k / 2;
            p = k % 2;
            if (active[k] && gprev[k]) begin
                q[k].delete(0);
                active[k] = 0;
            end
            gprev[k] = gnow[k];
            if (!active[k] && q[k].size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) active[k] = 1;
            t = active[k] ? q[k][0] : txn_t'($urandom);
            if (p == 0) begin
                req0[i] = active[k]; wr0[i] = t.wr; addr0[i] = t.a; wd0[i] = t.d;
            end else begin
                req1[i] = active[k]; wr1[i] = t.wr; addr1[i] = t.a; wd1[i] = t.d;
            end
        end
    endtask

    // Transaction-level rules: a free arbiter grants next cycle; a write frees it two cycles
    // after the decision, a read frees it at the response cycle RD_LAT after the grant.
    task automatic model();
        for (int i = 0; i < NI; i++) begin
            if (rst_n && cyc >= free_at[i] && (req0[i] || req1[i])) begin
                bit          w;
                bit          twr;
                logic [7:0]  ta;
                logic [15:0] td;
                int          g;
                int          l;
                w   = (req0[i] && req1[i]) ? ~last_m[i] : req1[i];
                last_m[i] = w;
                twr = w ? wr1[i] : wr0[i];
                ta  = w ? addr1[i] : addr0[i];
                td  = w ? wd1[i] : wd0[i];
                g   = cyc + 1;
                l   = lat_of(i);
                eg[i][w][g % 16] = 1;
                eaddr[i][g % 16] = ta;
                if (twr) begin
                    edwr[i][g % 16]  = 1;
                    ewd[i][g % 16]   = td;
                    ebusy[i][g % 16] = 1;
                    mmem[i][ta]      = td;
                    free_at[i]       = cyc + 2;
                end else begin
                    for (int b = 0; b <= l; b++) ebusy[i][(g + b) % 16] = 1;
                    erv[i][w][(g + l + 1) % 16] = 1;
                    erd[i][w][(g + l + 1) % 16] = mmem[i][ta];
                    mdl_rv[i]++;
                    free_at[i] = g + l;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            int s;
            s = cyc % 16;
            chk_val($sformatf("i%0d_gnt0", i), 32'(gnt0[i]), 32'(eg[i][0][s]));
            chk_val($sformatf("i%0d_gnt1", i), 32'(gnt1[i]), 32'(eg[i][1][s]));
            chk_val($sformatf("i%0d_rvalid0", i), 32'(rv0[i]), 32'(erv[i][0][s]));
            chk_val($sformatf("i%0d_rvalid1", i), 32'(rv1[i]), 32'(erv[i][1][s]));
            if (erv[i][0][s]) hold[i][0] = erd[i][0][s];
            if (erv[i][1][s]) hold[i][1] = erd[i][1][s];
            chk_val($sformatf("i%0d_rdata0", i), 32'(rd0[i]), 32'(hold[i][0]));
            chk_val($sformatf("i%0d_rdata1", i), 32'(rd1[i]), 32'(hold[i][1]));
            chk_val($sformatf("i%0d_d_wr", i), 32'(dwr[i]), 32'(edwr[i][s]));
            chk_val($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(ebusy[i][s]));
            if (eg[i][0][s] || eg[i][1][s]) begin
                chk_val($sformatf("i%0d_d_addr", i), 32'(daddr[i]), 32'(eaddr[i][s]));
                if (edwr[i][s]) chk_val($sformatf("i%0d_d_wdata", i), 32'(dwd[i]), 32'(ewd[i][s]));
            end
            eg[i][0][s] = 0; eg[i][1][s] = 0; erv[i][0][s] = 0; erv[i][1][s] = 0;
            edwr[i][s] = 0; ebusy[i][s] = 0;
            if (rv0[i]) dut_rv[i]++;
            if (rv1[i]) dut_rv[i]++;
            gnow[i*2]   = gnt0[i];
            gnow[i*2+1] = gnt1[i];
        end
        drive();
        model();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            active[k] = 0;
            gprev[k]  = 0;
            gnow[k]   = 0;
        end
        for (int i = 0; i < NI; i++) begin
            req0[i] = 0; wr0[i] = 0; addr0[i] = '0; wd0[i] = '0;
            req1[i] = 0; wr1[i] = 0; addr1[i] = '0; wd1[i] = '0;
        end
        clear_model();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk_val($sformatf("i%0d_rst_ctl", i),
                    32'({gnt0[i], gnt1[i], rv0[i], rv1[i], dwr[i], busy[i]}), 32'h0);
            chk_val($sformatf("i%0d_rst_addr", i), 32'(daddr[i]), 32'h0);
            chk_val($sformatf("i%0d_rst_data", i), {dwd[i], rd0[i] | rd1[i]}, 32'h0);
        end
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    task automatic push(input int i, input int p, input bit wr, input logic [7:0] a, input logic [15:0] d);
        txn_t t;
        t.wr = wr; t.a = a; t.d = d;
        q[i*2+p].push_back(t);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < 400) begin
            cycle();
            n++;
        end
        chk_val({tag, "_drain_timeout"}, 32'(n >= 400), 32'h0);
        repeat (10) cycle();
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < NI; i++)
            chk_val($sformatf("%s_i%0d_rvalid_count", tag, i), 32'(dut_rv[i]), 32'(mdl_rv[i]));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            dut_rv[i] = 0;
            mdl_rv[i] = 0;
            for (int a = 0; a < 256; a++) mmem[i][a] = 16'h0;
        end
        clear_model();
        do_reset(3);

        // Single write then a read of it by the other port.
        for (int i = 0; i < NI; i++) push(i, 0, 1'b1, 8'h10, 16'hBEEF);
        repeat (6) cycle();
        for (int i = 0; i < NI; i++) push(i, 1, 1'b0, 8'h10, 16'h0);
        repeat (10) cycle();
        for (int i = 0; i < NI; i++) begin
            chk_val($sformatf("i%0d_readback", i), 32'(rd1[i]), 32'hBEEF);
            chk_val($sformatf("i%0d_r0_rdata_idle", i), 32'(rd0[i]), 32'h0);
        end
        check_counts("directed");

        // Tie straight after reset, then both ports saturating with reads.
        do_reset(2);
        for (int i = 0; i < NI; i++) begin
            push(i, 0, 1'b0, 8'h10, 16'h0);
            push(i, 1, 1'b0, 8'h11, 16'h0);
        end
        repeat (12) cycle();
        for (int i = 0; i < NI; i++)
            for (int n = 0; n < 4; n++) begin
                push(i, 0, 1'b0, 8'($urandom_range(0, 15)), 16'h0);
                push(i, 1, 1'b0, 8'($urandom_range(0, 15)), 16'h0);
            end
        drain("alternate");
        check_counts("alternate");

        // Random mix of reads and writes on a small address window.
        gaps = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 4; k++)
                if (q[k].size() < 2 && $urandom_range(0, 3) == 0)
                    push(k / 2, k % 2, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
            cycle();
        end
        gaps = 0;
        drain("random");
        check_counts("random");

        // Reset in the middle of a slow read, then a tie.
        for (int i = 0; i < NI; i++) push(i, 0, 1'b0, 8'h10, 16'h0);
        repeat (3) cycle();
        chk_val("abort_busy_before", 32'(busy[1]), 32'h1);
        do_reset(2);
        for (int i = 0; i < NI; i++) begin
            push(i, 0, 1'b0, 8'h3, 16'h0);
            push(i, 1, 1'b0, 8'h4, 16'h0);
        end
        drain("after_abort");
        check_counts("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
